// File: rtl/uart_arb_pkg.sv
// Shared constants and state encoding for the UART transmit arbiter.
// The TAG state exists only when UART_ARB_TAG_EN is defined.
package uart_arb_pkg;

  localparam int unsigned MAX_REQ = 8;
  localparam int unsigned GRANT_W = 3;
  localparam int unsigned CNT_W   = 8;

  localparam logic [3:0] TAG_PREFIX = 4'hF;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE   = 2'd0;
  localparam state_t ST_STREAM = 2'd1;
`ifdef UART_ARB_TAG_EN
  localparam state_t ST_TAG    = 2'd2;
`endif

endpackage

// File: rtl/uart_rr_picker.sv
// Combinational round-robin search: first asserted request at or after ptr_i,
// wrapping modulo N_REQ.
module uart_rr_picker
  import uart_arb_pkg::*;
#(
  parameter int unsigned N_REQ = 4
) (
  input  logic [N_REQ-1:0]   req_i,
  input  logic [GRANT_W-1:0] ptr_i,
  output logic               found_o,
  output logic [GRANT_W-1:0] index_o
);

  logic [MAX_REQ-1:0] req_ext;
  logic [GRANT_W-1:0] cand;

  always_comb begin
    req_ext = MAX_REQ'(req_i);
    found_o = 1'b0;
    index_o = '0;
    cand    = '0;
    for (int unsigned k = 0; k < N_REQ; k++) begin
      cand = GRANT_W'((32'(ptr_i) + k) % N_REQ);
      if (!found_o && req_ext[cand]) begin
        found_o = 1'b1;
        index_o = cand;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin byte-stream arbiter feeding a UART transmitter; frames never interleave.
// Define UART_ARB_TAG_EN to prefix every granted frame with a tag byte (F0 | grant).
module uart_tx_arbiter
  import uart_arb_pkg::*;
#(
  parameter int unsigned N_REQ   = 4,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [N_REQ-1:0]      req_valid,
  input  logic [N_REQ-1:0][7:0] req_data,
  input  logic [N_REQ-1:0]      req_last,
  output logic [N_REQ-1:0]      req_ready,
  output logic                  out_valid,
  output logic [7:0]            out_data,
  input  logic                  out_ready,
  output logic [GRANT_W-1:0]    grant,
  output logic                  busy,
  output logic                  dropped
);

  state_t             state_q, state_d;
  logic [GRANT_W-1:0] grant_q, grant_d;
  logic [GRANT_W-1:0] ptr_q, ptr_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               dropped_q, dropped_d;

  logic                    pick_found;
  logic [GRANT_W-1:0]      pick_idx;
  logic [GRANT_W-1:0]      ptr_after;
  logic [MAX_REQ-1:0]      valid_ext, last_ext, ready_ext;
  logic [MAX_REQ-1:0][7:0] data_ext;

  uart_rr_picker #(
    .N_REQ (N_REQ)
  ) u_picker (
    .req_i   (req_valid),
    .ptr_i   (ptr_q),
    .found_o (pick_found),
    .index_o (pick_idx)
  );

  // Widen requester buses to a fixed size so the 3-bit grant indexes them exactly.
  always_comb begin
    valid_ext = '0;
    last_ext  = '0;
    data_ext  = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      valid_ext[i] = req_valid[i];
      last_ext[i]  = req_last[i];
      data_ext[i]  = req_data[i];
    end
  end

  assign ptr_after = GRANT_W'((32'(grant_q) + 32'd1) % N_REQ);

  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    ptr_d     = ptr_q;
    cnt_d     = cnt_q;
    dropped_d = 1'b0;
    out_valid = 1'b0;
    out_data  = '0;
    ready_ext = '0;
    case (state_q)
      ST_IDLE: begin
        if (pick_found) begin
          grant_d = pick_idx;
          cnt_d   = '0;
`ifdef UART_ARB_TAG_EN
          state_d = ST_TAG;
`else
          state_d = ST_STREAM;
`endif
        end
      end
`ifdef UART_ARB_TAG_EN
      ST_TAG: begin
        out_valid = 1'b1;
        out_data  = {TAG_PREFIX, 1'b0, grant_q};
        if (out_ready) begin
          state_d = ST_STREAM;
        end
      end
`endif
      ST_STREAM: begin
        out_valid            = valid_ext[grant_q];
        out_data             = data_ext[grant_q];
        ready_ext[grant_q]   = out_ready;
        if (valid_ext[grant_q]) begin
          cnt_d = '0;
          if (out_ready && last_ext[grant_q]) begin
            state_d = ST_IDLE;
            grant_d = '0;
            ptr_d   = ptr_after;
          end
        end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
          // This idle cycle brings the count to TIMEOUT: revoke the grant.
          state_d   = ST_IDLE;
          grant_d   = '0;
          ptr_d     = ptr_after;
          cnt_d     = '0;
          dropped_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
        grant_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      grant_q   <= '0;
      ptr_q     <= '0;
      cnt_q     <= '0;
      dropped_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      ptr_q     <= ptr_d;
      cnt_q     <= cnt_d;
      dropped_q <= dropped_d;
    end
  end

  assign req_ready = ready_ext[N_REQ-1:0];
  assign grant     = grant_q;
  assign busy      = (state_q != ST_IDLE);
  assign dropped   = dropped_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench for uart_tx_arbiter (N_REQ=4, TIMEOUT=4); follows UART_ARB_TAG_EN.
module tb_uart_tx_arbiter;

  localparam int unsigned N  = 4;
  localparam int unsigned TO = 4;

  typedef struct packed { logic [7:0] data; logic last; } drv_t;
  typedef struct packed { logic [7:0] data; logic [2:0] grant; } exp_t;

  logic            clk = 1'b0;
  logic            reset;
  logic [N-1:0]    req_valid;
  logic [N-1:0][7:0] req_data;
  logic [N-1:0]    req_last;
  logic [N-1:0]    req_ready;
  logic            out_valid;
  logic [7:0]      out_data;
  logic            out_ready;
  logic [2:0]      grant;
  logic            busy;
  logic            dropped;

  int checks   = 0;
  int failures = 0;

  drv_t         drv_q[N][$];
  exp_t         exp_q[$];
  logic [N-1:0] acc;

  uart_tx_arbiter #(
    .N_REQ   (N),
    .TIMEOUT (TO)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_last  (req_last),
    .req_ready (req_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ready (out_ready),
    .grant     (grant),
    .busy      (busy),
    .dropped   (dropped)
  );

  always #5 clk = ~clk;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endfunction

  function automatic logic [7:0] first_byte(input int unsigned g, input logic [7:0] d);
`ifdef UART_ARB_TAG_EN
    return 8'hF0 | 8'(g);
`else
    return d;
`endif
  endfunction

  function automatic bit drv_empty();
    for (int i = 0; i < N; i++) if (drv_q[i].size() != 0) return 1'b0;
    return 1'b1;
  endfunction

  // Queue a frame on requester r and record its expected bytes in arbitration order.
  task automatic add_frame(input int unsigned r, input int n, input bit has_last,
                           input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2);
    logic [7:0] bs [3];
    bs[0] = b0; bs[1] = b1; bs[2] = b2;
`ifdef UART_ARB_TAG_EN
    exp_q.push_back('{data: 8'hF0 | 8'(r), grant: 3'(r)});
`endif
    for (int k = 0; k < n; k++) begin
      drv_q[r].push_back('{data: bs[k], last: has_last && (k == n - 1)});
      exp_q.push_back('{data: bs[k], grant: 3'(r)});
    end
  endtask

  task automatic wait_byte(input string name, input logic [7:0] d, input logic [2:0] g);
    bit seen = 1'b0;
    for (int n = 0; n < 100 && !seen; n++) begin
      @(negedge clk); #2;
      seen = out_valid && (out_data == d) && (grant == g);
    end
    chk(name, 32'(seen), 32'd1);
  endtask

  task automatic wait_idle(input string name);
    bit done = 1'b0;
    for (int n = 0; n < 300 && !done; n++) begin
      @(negedge clk); #2;
      done = (exp_q.size() == 0) && !busy && drv_empty();
    end
    chk(name, 32'(done), 32'd1);
  endtask

  task automatic chk_reset(input string name);
    chk({name, "_busy"},    32'(busy),      32'd0);
    chk({name, "_grant"},   32'(grant),     32'd0);
    chk({name, "_ovalid"},  32'(out_valid), 32'd0);
    chk({name, "_odata"},   32'(out_data),  32'd0);
    chk({name, "_rready"},  32'(req_ready), 32'd0);
    chk({name, "_dropped"}, 32'(dropped),   32'd0);
  endtask

  // Requester driver: present queue heads, retire a byte after its handshake.
  initial begin
    req_valid = '0;
    req_data  = '0;
    req_last  = '0;
    acc       = '0;
    forever begin
      @(negedge clk);
      for (int i = 0; i < N; i++) begin
        if (acc[i] && drv_q[i].size() > 0) drv_q[i].delete(0);
        if (drv_q[i].size() > 0) begin
          req_valid[i] = 1'b1;
          req_data[i]  = drv_q[i][0].data;
          req_last[i]  = drv_q[i][0].last;
        end else begin
          req_valid[i] = 1'b0;
          req_data[i]  = '0;
          req_last[i]  = 1'b0;
        end
      end
      #1;
      for (int i = 0; i < N; i++) acc[i] = req_valid[i] && req_ready[i];
    end
  end

  // Monitor: every accepted output byte must match the scoreboard head.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk); #1;
      if (reset !== 1'b1 && out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          chk("sb_unexpected", 32'(out_data), 32'h1FF);
        end else begin
          e = exp_q.pop_front();
          chk("sb_data",  32'(out_data), 32'(e.data));
          chk("sb_grant", 32'(grant),    32'(e.grant));
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset     = 1'b1;
    out_ready = 1'b1;
    repeat (2) @(negedge clk);
    #2;
    chk_reset("reset");
    @(negedge clk);
    reset = 1'b0;
    #2;

    // Contention from ptr=0: frame 0 then frame 1, then ptr=2 favours 2 over 1.
    add_frame(0, 2, 1'b1, 8'hA0, 8'hA1, 8'h00);
    add_frame(1, 2, 1'b1, 8'hB0, 8'hB1, 8'h00);
    wait_idle("cont_drain");
    add_frame(2, 1, 1'b1, 8'h2A, 8'h00, 8'h00);
    add_frame(1, 1, 1'b1, 8'h1B, 8'h00, 8'h00);
    wait_idle("rr2_drain");

    // Single requester with one-cycle arbitration latency.
    add_frame(2, 2, 1'b1, 8'h41, 8'h42, 8'h00);
    @(negedge clk); #2;
    chk("single_arb_busy",   32'(busy),      32'd0);
    chk("single_arb_ovalid", 32'(out_valid), 32'd0);
    @(negedge clk); #2;
    chk("single_grant", 32'(grant),     32'd2);
    chk("single_busy",  32'(busy),      32'd1);
    chk("single_first", 32'(out_data),  32'(first_byte(2, 8'h41)));
    wait_idle("single_drain");

    // ptr is now 3: requester 3 beats requester 0.
    add_frame(3, 1, 1'b1, 8'h33, 8'h00, 8'h00);
    add_frame(0, 1, 1'b1, 8'h30, 8'h00, 8'h00);
    wait_idle("ptr3_drain");

    // Backpressure on requester 1 while requester 0 waits.
    add_frame(1, 3, 1'b1, 8'hC0, 8'hC1, 8'hC2);
    add_frame(0, 1, 1'b1, 8'hD0, 8'h00, 8'h00);
    wait_byte("bp_sync", 8'hC0, 3'd1);
    chk("bp_ready_on", 32'(req_ready), 32'h2);
    @(negedge clk);
    out_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      #2;
      chk("bp_hold_data",   32'(out_data),  32'hC1);
      chk("bp_hold_valid",  32'(out_valid), 32'd1);
      chk("bp_hold_ready",  32'(req_ready), 32'h0);
      chk("bp_hold_grant",  32'(grant),     32'd1);
      chk("bp_hold_nodrop", 32'(dropped),   32'd0);
      @(negedge clk);
    end
    out_ready = 1'b1;
    #2;
    chk("bp_release_ready", 32'(req_ready), 32'h2);
    wait_idle("bp_drain");

    // Timeout: requester 2 stalls after one byte; requester 3 then wins.
    add_frame(2, 1, 1'b0, 8'hE0, 8'h00, 8'h00);
    add_frame(3, 1, 1'b1, 8'h77, 8'h00, 8'h00);
    wait_byte("to_sync", 8'hE0, 3'd2);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk); #2;
      chk("to_wait_dropped", 32'(dropped),   32'd0);
      chk("to_wait_busy",    32'(busy),      32'd1);
      chk("to_wait_grant",   32'(grant),     32'd2);
      chk("to_wait_ovalid",  32'(out_valid), 32'd0);
    end
    @(negedge clk); #2;
    chk("to_dropped", 32'(dropped), 32'd1);
    chk("to_busy",    32'(busy),    32'd0);
    chk("to_grant",   32'(grant),   32'd0);
    @(negedge clk); #2;
    chk("to_pulse_end", 32'(dropped), 32'd0);
    chk("to_next_grant", 32'(grant),  32'd3);
    wait_idle("to_drain");

    // Reset mid-frame abandons it; requester 3 alone is granted afterwards.
    add_frame(1, 3, 1'b1, 8'h60, 8'h61, 8'h62);
    wait_byte("rst_sync", 8'h61, 3'd1);
    @(negedge clk);
    reset = 1'b1;
    exp_q.delete();
    for (int i = 0; i < N; i++) drv_q[i].delete();
    #2;
    chk_reset("rst_mid");
    repeat (2) @(negedge clk);
    reset = 1'b0;
    #2;
    add_frame(3, 1, 1'b1, 8'h99, 8'h00, 8'h00);
    @(negedge clk); #2;
    chk("rst_arb_busy", 32'(busy),  32'd0);
    @(negedge clk); #2;
    chk("rst_grant",    32'(grant), 32'd3);
    chk("rst_busy",     32'(busy),  32'd1);
    wait_idle("rst_drain");

    // Single-byte frame from requester 1 (tag byte precedes it when enabled).
    add_frame(1, 1, 1'b1, 8'h55, 8'h00, 8'h00);
    @(negedge clk); #2;
    @(negedge clk); #2;
    chk("b55_first", 32'(out_data), 32'(first_byte(1, 8'h55)));
    wait_idle("b55_drain");

    chk("sb_final", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
